// File: rtl/explosion_object_draw.sv
//------------------------------------------------------------------------------
// Module  : explosion_object_draw
// Brief   : Procedural cross-shaped explosion sprite with phased growth animation.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module explosion_object_draw #(
  parameter int          OBJ_SIZE         = 32,
  parameter int          ARM_W            = 8,
  parameter int          NUM_PHASES       = 4,
  parameter int          FRAMES_PER_PHASE = 4,
  parameter logic [7:0]  COLOR_0          = 8'hFC,
  parameter logic [7:0]  COLOR_1          = 8'hF8,
  parameter logic [7:0]  COLOR_2          = 8'hE0,
  parameter logic [7:0]  COLOR_3          = 8'hA0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        trigger,
  input  logic [10:0] topLeftX,
  input  logic [10:0] topLeftY,
  output logic        drawingRequest,
  output logic [7:0]  RGBout,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_FRAME = 2'd1,
    S_ACTIVE     = 2'd2
  } state_t;

  localparam logic [11:0] c_obj_size   = 12'(OBJ_SIZE);
  localparam logic [11:0] c_obj_half   = 12'(OBJ_SIZE / 2);
  localparam logic [11:0] c_arm_half   = 12'(ARM_W / 2);
  localparam logic [2:0]  c_last_phase = 3'(NUM_PHASES - 1);
  localparam logic [7:0]  c_last_frame = 8'(FRAMES_PER_PHASE - 1);

  state_t      state_q;
  logic [2:0]  phase_q;
  logic [7:0]  frame_q;
  logic [10:0] pos_x_q;
  logic [10:0] pos_y_q;
  logic        done_q;
  logic        dr_q;
  logic [7:0]  rgb_q;

  logic [11:0] w_off_x;
  logic [11:0] w_off_y;
  logic [11:0] w_dx;
  logic [11:0] w_dy;
  logic [11:0] w_abs_dx;
  logic [11:0] w_abs_dy;
  logic [11:0] w_len;
  logic        w_inside;
  logic        w_lit;
  logic        w_draw;
  logic [7:0]  w_color;

  function automatic logic [11:0] arm_len(input logic [2:0] ph);
    return 12'(((int'(ph) + 1) * OBJ_SIZE) / (2 * NUM_PHASES));
  endfunction

  function automatic logic [7:0] phase_color(input logic [2:0] ph);
    case (ph)
      3'd0:    return COLOR_0;
      3'd1:    return COLOR_1;
      3'd2:    return COLOR_2;
      default: return COLOR_3;
    endcase
  endfunction

  // Zero-extended 11-bit operands make the 12-bit difference an exact signed offset.
  always_comb begin
    w_off_x  = {1'b0, pixelX} - {1'b0, pos_x_q};
    w_off_y  = {1'b0, pixelY} - {1'b0, pos_y_q};
    w_inside = !w_off_x[11] && (w_off_x < c_obj_size) &&
               !w_off_y[11] && (w_off_y < c_obj_size);
    w_dx     = w_off_x - c_obj_half;
    w_dy     = w_off_y - c_obj_half;
    w_abs_dx = w_dx[11] ? (12'd0 - w_dx) : w_dx;
    w_abs_dy = w_dy[11] ? (12'd0 - w_dy) : w_dy;
    w_len    = arm_len(phase_q);
    w_lit    = w_inside &&
               (((w_abs_dy < c_arm_half) && (w_abs_dx < w_len)) ||
                ((w_abs_dx < c_arm_half) && (w_abs_dy < w_len)));
    w_draw   = w_lit && (state_q == S_ACTIVE);
    w_color  = phase_color(phase_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      phase_q <= 3'd0;
      frame_q <= 8'd0;
      pos_x_q <= 11'd0;
      pos_y_q <= 11'd0;
      done_q  <= 1'b0;
      dr_q    <= 1'b0;
      rgb_q   <= 8'h00;
    end else begin
      done_q <= 1'b0;
      dr_q   <= w_draw;
      rgb_q  <= w_draw ? w_color : 8'h00;
      case (state_q)
        S_IDLE: begin
          // A coincident startOfFrame is deliberately not consumed here.
          if (trigger) begin
            pos_x_q <= topLeftX;
            pos_y_q <= topLeftY;
            state_q <= S_WAIT_FRAME;
          end
        end
        S_WAIT_FRAME: begin
          if (startOfFrame) begin
            state_q <= S_ACTIVE;
            phase_q <= 3'd0;
            frame_q <= 8'd0;
          end
        end
        S_ACTIVE: begin
          if (startOfFrame) begin
            if (frame_q < c_last_frame) begin
              frame_q <= frame_q + 8'd1;
            end else begin
              frame_q <= 8'd0;
              if (phase_q == c_last_phase) begin
                phase_q <= 3'd0;
                state_q <= S_IDLE;
                done_q  <= 1'b1;
              end else begin
                phase_q <= phase_q + 3'd1;
              end
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign drawingRequest = dr_q;
  assign RGBout         = rgb_q;
  assign busy           = (state_q != S_IDLE);
  assign done           = done_q;

endmodule

`default_nettype wire

// File: tb/tb_explosion_object_draw.sv
//------------------------------------------------------------------------------
// Module  : tb_explosion_object_draw
// Brief   : Directed self-checking bench for explosion_object_draw.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_explosion_object_draw;

  logic        clk;
  logic        reset;
  logic        startOfFrame;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic        trigger;
  logic [10:0] topLeftX;
  logic [10:0] topLeftY;
  logic        drawingRequest;
  logic [7:0]  RGBout;
  logic        busy;
  logic        done;

  int pass_cnt  = 0;
  int total_cnt = 0;

  explosion_object_draw dut (
    .clk           (clk),
    .reset         (reset),
    .startOfFrame  (startOfFrame),
    .pixelX        (pixelX),
    .pixelY        (pixelY),
    .trigger       (trigger),
    .topLeftX      (topLeftX),
    .topLeftY      (topLeftY),
    .drawingRequest(drawingRequest),
    .RGBout        (RGBout),
    .busy          (busy),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sof_pulse();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  task automatic present(input int x, input int y);
    pixelX = 11'(x);
    pixelY = 11'(y);
    tick();
  endtask

  task automatic fire(input int x, input int y);
    topLeftX = 11'(x);
    topLeftY = 11'(y);
    trigger  = 1'b1;
    tick();
    trigger  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      present(0, 0);
      total_cnt++;
      if (drawingRequest !== 1'b0 || RGBout !== 8'h00 || busy !== 1'b0 || done !== 1'b0)
        $display("FAIL reset_idle cyc%0d: dr=%b rgb=%h busy=%b done=%b, want 0 00 0 0",
                 i, drawingRequest, RGBout, busy, done);
      else pass_cnt++;
    end
  endtask

  task automatic test_phase0();
    fire(100, 50);
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL trig_busy: busy=%b want 1", busy);
    else pass_cnt++;
    present(116, 66);
    total_cnt++;
    if (drawingRequest !== 1'b0)
      $display("FAIL wait_frame_dark: dr=%b want 0", drawingRequest);
    else pass_cnt++;
    sof_pulse();  // SOF 1: enter ACTIVE
    present(116, 66);
    total_cnt++;
    if (drawingRequest !== 1'b1 || RGBout !== 8'hFC)
      $display("FAIL p0_center: dr=%b rgb=%h want 1 fc", drawingRequest, RGBout);
    else pass_cnt++;
    present(121, 66);
    total_cnt++;
    if (drawingRequest !== 1'b0 || RGBout !== 8'h00)
      $display("FAIL p0_dx5: dr=%b rgb=%h want 0 00", drawingRequest, RGBout);
    else pass_cnt++;
  endtask

  task automatic test_phase1();
    repeat (4) sof_pulse();  // SOF 2..5
    present(121, 66);
    total_cnt++;
    if (drawingRequest !== 1'b1 || RGBout !== 8'hF8)
      $display("FAIL p1_dx5: dr=%b rgb=%h want 1 f8", drawingRequest, RGBout);
    else pass_cnt++;
    present(99, 66);
    total_cnt++;
    if (drawingRequest !== 1'b0 || RGBout !== 8'h00)
      $display("FAIL p1_outside: dr=%b rgb=%h want 0 00", drawingRequest, RGBout);
    else pass_cnt++;
    present(116, 73);
    total_cnt++;
    if (drawingRequest !== 1'b1) $display("FAIL p1_dy7: dr=%b want 1", drawingRequest);
    else pass_cnt++;
    present(116, 74);
    total_cnt++;
    if (drawingRequest !== 1'b0) $display("FAIL p1_dy8: dr=%b want 0", drawingRequest);
    else pass_cnt++;
    present(120, 70);
    total_cnt++;
    if (drawingRequest !== 1'b0) $display("FAIL p1_diag: dr=%b want 0", drawingRequest);
    else pass_cnt++;
  endtask

  task automatic test_retrigger_ignored();
    fire(300, 300);
    present(116, 66);
    total_cnt++;
    if (drawingRequest !== 1'b1 || busy !== 1'b1)
      $display("FAIL retrig_old_pos: dr=%b busy=%b want 1 1", drawingRequest, busy);
    else pass_cnt++;
    present(316, 316);
    total_cnt++;
    if (drawingRequest !== 1'b0)
      $display("FAIL retrig_new_pos: dr=%b want 0", drawingRequest);
    else pass_cnt++;
  endtask

  task automatic test_done();
    bit early_done = 1'b0;
    for (int s = 6; s <= 16; s++) begin
      sof_pulse();
      if (done !== 1'b0 || busy !== 1'b1) early_done = 1'b1;
      if (s == 9) begin
        present(127, 66);
        total_cnt++;
        if (drawingRequest !== 1'b1 || RGBout !== 8'hE0)
          $display("FAIL p2_dx11: dr=%b rgb=%h want 1 e0", drawingRequest, RGBout);
        else pass_cnt++;
      end
      if (s == 13) begin
        present(131, 66);
        total_cnt++;
        if (drawingRequest !== 1'b1 || RGBout !== 8'hA0)
          $display("FAIL p3_dx15: dr=%b rgb=%h want 1 a0", drawingRequest, RGBout);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (early_done) $display("FAIL early_done: done/busy wrong before SOF 17");
    else pass_cnt++;
    sof_pulse();  // SOF 17
    total_cnt++;
    if (done !== 1'b1 || busy !== 1'b0)
      $display("FAIL done_pulse: done=%b busy=%b want 1 0", done, busy);
    else pass_cnt++;
    present(116, 66);
    total_cnt++;
    if (done !== 1'b0 || drawingRequest !== 1'b0 || busy !== 1'b0)
      $display("FAIL after_done: done=%b dr=%b busy=%b want 0 0 0", done, drawingRequest, busy);
    else pass_cnt++;
  endtask

  task automatic test_trigger_with_sof();
    topLeftX     = 11'd100;
    topLeftY     = 11'd50;
    trigger      = 1'b1;
    startOfFrame = 1'b1;
    tick();
    trigger      = 1'b0;
    startOfFrame = 1'b0;
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL trig_sof_busy: busy=%b want 1", busy);
    else pass_cnt++;
    present(116, 66);
    present(116, 66);
    total_cnt++;
    if (drawingRequest !== 1'b0)
      $display("FAIL trig_sof_not_consumed: dr=%b want 0", drawingRequest);
    else pass_cnt++;
    sof_pulse();
    present(116, 66);
    total_cnt++;
    if (drawingRequest !== 1'b1 || RGBout !== 8'hFC)
      $display("FAIL trig_sof_draw: dr=%b rgb=%h want 1 fc", drawingRequest, RGBout);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    repeat (8) sof_pulse();  // reach phase 2
    present(116, 66);
    total_cnt++;
    if (RGBout !== 8'hE0) $display("FAIL mid_phase2: rgb=%h want e0", RGBout);
    else pass_cnt++;
    reset        = 1'b1;
    startOfFrame = 1'b1;
    present(116, 66);
    reset        = 1'b0;
    startOfFrame = 1'b0;
    total_cnt++;
    if (busy !== 1'b0 || drawingRequest !== 1'b0 || done !== 1'b0)
      $display("FAIL mid_reset: busy=%b dr=%b done=%b want 0 0 0", busy, drawingRequest, done);
    else pass_cnt++;
    present(116, 66);
    total_cnt++;
    if (done !== 1'b0 || drawingRequest !== 1'b0)
      $display("FAIL mid_reset_after: done=%b dr=%b want 0 0", done, drawingRequest);
    else pass_cnt++;
    fire(100, 50);
    sof_pulse();
    present(116, 66);
    total_cnt++;
    if (drawingRequest !== 1'b1 || RGBout !== 8'hFC)
      $display("FAIL restart_p0: dr=%b rgb=%h want 1 fc", drawingRequest, RGBout);
    else pass_cnt++;
    present(121, 66);
    total_cnt++;
    if (drawingRequest !== 1'b0)
      $display("FAIL restart_L4: dr=%b want 0", drawingRequest);
    else pass_cnt++;
  endtask

  initial begin
    reset        = 1'b1;
    startOfFrame = 1'b0;
    pixelX       = 11'd0;
    pixelY       = 11'd0;
    trigger      = 1'b0;
    topLeftX     = 11'd0;
    topLeftY     = 11'd0;
    test_reset();
    test_phase0();
    test_phase1();
    test_retrigger_ignored();
    test_done();
    test_trigger_with_sof();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
